// File: rtl/multipli_arb_pkg.sv
// Shared types and defaults for the multiplier arbiter.
//   arb_state_t     : sequencer states of the arbiter FSM
//   TIMEOUT_DEFAULT : default number of WAIT cycles before an operation aborts
package multipli_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    ABORT   = 3'd4
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/multipli_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req         : request levels, one bit per requester
//   mask        : requesters excluded from this pick
//   pointer     : index that has highest priority this cycle
//   grant_valid : at least one unmasked request is present
//   grant_idx   : first unmasked request at or after pointer, cyclically
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] pointer,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [N_REQ-1:0] eligible;

  assign eligible = req & ~mask;

  // Scan from the farthest offset down to offset 0 so the candidate
  // closest to the pointer is the one left standing.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = int'(pointer) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (eligible[IDX_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/multipli_arbiter.sv
// Round-robin arbiter/sequencer sharing one sum-and-shift multiplier among
// N_REQ requesters, with a per-operation timeout.
// Ports:
//   CLK, RESET_N : clock (posedge) and asynchronous active-low reset
//   req          : per-requester request level, held until done/err
//   a_in, b_in   : packed operands, slice i = [i*size +: size]
//   done, err    : one-cycle pulse to the served requester (success/timeout)
//   result       : registered product, valid while a done bit is high
//   busy         : operation in progress (ISSUE through DELIVER/ABORT)
//   owner        : index of the requester being served
//   start        : one-cycle multiplier start
//   A, B         : operands held for the multiplier
//   S, fin_mult  : multiplier product and completion level
module multipli_arbiter
  import multipli_arb_pkg::*;
#(
  parameter int  size    = 8,
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = TIMEOUT_DEFAULT,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*size-1:0] a_in,
  input  logic [N_REQ*size-1:0] b_in,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic [2*size-1:0]     result,
  output logic                  busy,
  output logic [IDX_W-1:0]      owner,
  output logic                  start,
  output logic [size-1:0]       A,
  output logic [size-1:0]       B,
  input  logic [2*size-1:0]     S,
  input  logic                  fin_mult
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] pointer;
  logic             mask_pend;
  logic [N_REQ-1:0] mask;
  logic             fin_mult_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             fin_edge;
  logic             tmo_last;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign fin_edge = fin_mult & ~fin_mult_q;
  assign tmo_last = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // The just-served requester is hidden for one IDLE cycle so it has time
  // to drop req before it can win again.
  always_comb begin
    mask = '0;
    if (mask_pend) mask[owner] = 1'b1;
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (req),
    .mask        (mask),
    .pointer     (pointer),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    done      = '0;
    err       = '0;
    case (state)
      IDLE: begin
        if (grant_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        start     = 1'b1;
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        // A completion edge on the final timeout cycle still counts.
        if (fin_edge)      state_nxt = DELIVER;
        else if (tmo_last) state_nxt = ABORT;
      end
      DELIVER: begin
        busy        = 1'b1;
        done[owner] = 1'b1;
        state_nxt   = IDLE;
      end
      ABORT: begin
        busy       = 1'b1;
        err[owner] = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pointer    <= '0;
      owner      <= '0;
      mask_pend  <= 1'b0;
      fin_mult_q <= 1'b0;
      tmo_cnt    <= '0;
      A          <= '0;
      B          <= '0;
      result     <= '0;
    end else begin
      fin_mult_q <= fin_mult;
      case (state)
        IDLE: begin
          mask_pend <= 1'b0;
          if (grant_valid) begin
            owner <= grant_idx;
            A     <= a_in[grant_idx*size +: size];
            B     <= b_in[grant_idx*size +: size];
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (fin_edge) result <= S;
        end
        DELIVER, ABORT: begin
          pointer   <= wrap_inc(owner);
          mask_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multipli_arbiter.sv
`timescale 1ns/1ps
module tb_multipli_arbiter;
  localparam int SIZE = 8;
  localparam int NR   = 4;
  localparam int TMO  = 64;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic [NR-1:0]    req;
  logic [NR*SIZE-1:0] a_in, b_in;
  logic [NR-1:0]    done, err;
  logic [2*SIZE-1:0] result;
  logic             busy;
  logic [1:0]       owner;
  logic             start;
  logic [SIZE-1:0]  A, B;
  logic [2*SIZE-1:0] S;
  logic             fin_mult;

  int checks = 0;
  int errors = 0;
  int exp_ptr;
  logic [15:0] last_exp_res;

  int          delay_q[$];
  int          scr_q[$];
  int          ev_idx[$];
  logic [3:0]  ev_done[$];
  logic [3:0]  ev_err[$];
  logic [15:0] ev_res[$];
  int          ev_cyc[$];
  int          st_cyc[$];

  always #5 CLK = ~CLK;

  multipli_arbiter #(.size(SIZE), .N_REQ(NR), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req(req), .a_in(a_in), .b_in(b_in),
    .done(done), .err(err), .result(result), .busy(busy), .owner(owner),
    .start(start), .A(A), .B(B), .S(S), .fin_mult(fin_mult)
  );

  function automatic logic [15:0] prodf(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] p;
    p = 16'(a) * 16'(b);
    return p;
  endfunction

  // Behavioural multiplier: after a start, waits d cycles then raises
  // fin_mult for one cycle with S = A*B. d = 0 means it never answers.
  initial begin : mult_model
    logic signed [7:0] pa, pb;
    int d;
    bit alive;
    fin_mult = 1'b0;
    S = '0;
    forever begin
      @(negedge CLK);
      if (RESET_N === 1'b1 && start === 1'b1) begin
        pa = A;
        pb = B;
        d = (delay_q.size() > 0) ? delay_q.pop_front() : 2;
        if (d > 0) begin
          alive = 1'b1;
          for (int k = 0; k < d; k++) begin
            @(negedge CLK);
            if (RESET_N !== 1'b1) alive = 1'b0;
          end
          if (alive) begin
            S = prodf(pa, pb);
            fin_mult = 1'b1;
            @(negedge CLK);
            fin_mult = 1'b0;
          end
        end
      end
    end
  end

  // Requester behaviour: watches outputs each cycle, logs start/done/err
  // events and drops req on service (held bits stay for one extra service).
  task automatic collect(input int n_ops, input int max_cyc,
                         input logic [3:0] hold_in, input logic [3:0] add_on_start);
    int cyc, nev, ix;
    logic [3:0] hold;
    bit added;
    hold = hold_in; added = 1'b0; cyc = 0; nev = 0;
    ev_idx.delete(); ev_done.delete(); ev_err.delete();
    ev_res.delete(); ev_cyc.delete(); st_cyc.delete();
    while (nev < n_ops && cyc < max_cyc) begin
      @(negedge CLK);
      cyc++;
      if (start === 1'b1) begin
        st_cyc.push_back(cyc);
        if (!added) begin req = req | add_on_start; added = 1'b1; end
        if (scr_q.size() > 0) begin
          ix = scr_q.pop_front();
          a_in[ix*SIZE +: SIZE] = 8'($urandom);
          b_in[ix*SIZE +: SIZE] = 8'($urandom);
        end
      end
      if ((done | err) !== 4'b0) begin
        ix = 0;
        for (int i = 3; i >= 0; i--) if (done[i] === 1'b1 || err[i] === 1'b1) ix = i;
        ev_idx.push_back(ix); ev_done.push_back(done); ev_err.push_back(err);
        ev_res.push_back(result); ev_cyc.push_back(cyc);
        nev++;
        if (hold[ix]) hold[ix] = 1'b0;
        else          req[ix]  = 1'b0;
      end
    end
    scr_q.delete();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; req = '0; a_in = '0; b_in = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({done, err, busy, start, owner} !== 11'b0) begin
      errors++; $display("FAIL reset_ctrl: got %0h expected 0", {done, err, busy, start, owner});
    end
    checks++;
    if ({A, B, result} !== 32'b0) begin
      errors++; $display("FAIL reset_data: got %0h expected 0", {A, B, result});
    end
    RESET_N = 1'b1;
    exp_ptr = 0; last_exp_res = '0;
  endtask

  task automatic test_single();
    delay_q.delete(); delay_q.push_back(3);
    a_in[7:0] = 8'hD3; b_in[7:0] = 8'd96;  // -45 * 96
    req = 4'b0001;
    collect(1, 100, 4'b0, 4'b0);
    checks++;
    if (ev_idx.size() !== 1 || st_cyc.size() !== 1) begin
      errors++; $display("FAIL single_count: got %0d/%0d expected 1/1", ev_idx.size(), st_cyc.size());
    end else begin
      checks++;
      if (ev_done[0] !== 4'b0001 || ev_err[0] !== 4'b0) begin
        errors++; $display("FAIL single_done: got %b/%b expected 0001/0000", ev_done[0], ev_err[0]);
      end
      checks++;
      if (ev_res[0] !== 16'hEF20) begin
        errors++; $display("FAIL single_result: got %h expected ef20", ev_res[0]);
      end
      checks++;
      if (ev_cyc[0] !== 5 || st_cyc[0] !== 1) begin
        errors++; $display("FAIL single_latency: got %0d/%0d expected 5/1", ev_cyc[0], st_cyc[0]);
      end
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_after: got %b expected 0", busy);
    end
    exp_ptr = 1; last_exp_res = 16'hEF20;
  endtask

  task automatic test_simultaneous();
    RESET_N = 1'b0; @(negedge CLK); RESET_N = 1'b1;
    delay_q.delete();
    for (int i = 0; i < 4; i++) begin
      a_in[i*SIZE +: SIZE] = 8'(i + 1);
      b_in[i*SIZE +: SIZE] = 8'd3;
      delay_q.push_back($urandom_range(1, 4));
    end
    req = 4'b1111;
    collect(4, 300, 4'b0, 4'b0);
    checks++;
    if (ev_idx.size() !== 4 || st_cyc.size() !== 4) begin
      errors++; $display("FAIL simul_count: got %0d/%0d expected 4/4", ev_idx.size(), st_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ev_done[k] !== 4'(1 << k) || ev_res[k] !== 16'(3 * (k + 1))) begin
          errors++; $display("FAIL simul_op%0d: got done=%b res=%0d expected done=%b res=%0d",
                             k, ev_done[k], ev_res[k], 4'(1 << k), 3 * (k + 1));
        end
      end
    end
    exp_ptr = 0; last_exp_res = 16'd12;
  endtask

  task automatic test_fairness();
    int exp_i[3];
    logic [15:0] exp_r[3];
    exp_i = '{1, 2, 1};
    exp_r = '{prodf(8'sd7, -8'sd9), prodf(8'sd10, 8'sd11), prodf(8'sd7, -8'sd9)};
    delay_q.delete(); repeat (3) delay_q.push_back(2);
    a_in[1*SIZE +: SIZE] = 8'd7;  b_in[1*SIZE +: SIZE] = 8'hF7;
    a_in[2*SIZE +: SIZE] = 8'd10; b_in[2*SIZE +: SIZE] = 8'd11;
    req = 4'b0010;
    collect(3, 300, 4'b0010, 4'b0100);
    checks++;
    if (ev_idx.size() !== 3) begin
      errors++; $display("FAIL fair_count: got %0d expected 3", ev_idx.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ev_done[k] !== 4'(1 << exp_i[k]) || ev_res[k] !== exp_r[k]) begin
          errors++; $display("FAIL fair_op%0d: got done=%b res=%h expected done=%b res=%h",
                             k, ev_done[k], ev_res[k], 4'(1 << exp_i[k]), exp_r[k]);
        end
      end
    end
    exp_ptr = 2; last_exp_res = exp_r[2];
  endtask

  task automatic test_mask();
    delay_q.delete(); delay_q.push_back(1); delay_q.push_back(1);
    a_in[7:0] = 8'd20; b_in[7:0] = 8'hFA;  // 20 * -6
    req = 4'b0001;
    collect(2, 100, 4'b0001, 4'b0);
    checks++;
    if (ev_idx.size() !== 2 || st_cyc.size() !== 2) begin
      errors++; $display("FAIL mask_count: got %0d/%0d expected 2/2", ev_idx.size(), st_cyc.size());
    end else begin
      checks++;
      if (st_cyc[1] - ev_cyc[0] !== 3) begin
        errors++; $display("FAIL mask_gap: got %0d expected 3", st_cyc[1] - ev_cyc[0]);
      end
      checks++;
      if (ev_done[1] !== 4'b0001 || ev_res[1] !== prodf(8'sd20, -8'sd6)) begin
        errors++; $display("FAIL mask_op: got done=%b res=%h expected 0001/%h", ev_done[1], ev_res[1], prodf(8'sd20, -8'sd6));
      end
    end
    exp_ptr = 1; last_exp_res = prodf(8'sd20, -8'sd6);
  endtask

  task automatic test_timeout();
    delay_q.delete(); delay_q.push_back(0); delay_q.push_back(2);
    a_in[3*SIZE +: SIZE] = 8'd100; b_in[3*SIZE +: SIZE] = 8'd100;
    req = 4'b1100;
    collect(2, 400, 4'b0, 4'b0);
    checks++;
    if (ev_idx.size() !== 2 || st_cyc.size() !== 2) begin
      errors++; $display("FAIL tmo_count: got %0d/%0d expected 2/2", ev_idx.size(), st_cyc.size());
    end else begin
      checks++;
      if (ev_err[0] !== 4'b0100 || ev_done[0] !== 4'b0) begin
        errors++; $display("FAIL tmo_err: got err=%b done=%b expected 0100/0000", ev_err[0], ev_done[0]);
      end
      checks++;
      if (ev_cyc[0] - st_cyc[0] !== TMO + 1) begin
        errors++; $display("FAIL tmo_timing: got %0d expected %0d", ev_cyc[0] - st_cyc[0], TMO + 1);
      end
      checks++;
      if (ev_res[0] !== last_exp_res) begin
        errors++; $display("FAIL tmo_result_kept: got %h expected %h", ev_res[0], last_exp_res);
      end
      checks++;
      if (ev_done[1] !== 4'b1000 || ev_res[1] !== 16'd10000) begin
        errors++; $display("FAIL tmo_next: got done=%b res=%0d expected 1000/10000", ev_done[1], ev_res[1]);
      end
    end
    exp_ptr = 0; last_exp_res = 16'd10000;
  endtask

  task automatic test_zero_coincide();
    delay_q.delete(); delay_q.push_back(2); delay_q.push_back(TMO); delay_q.push_back(TMO + 1);
    a_in[0*SIZE +: SIZE] = 8'd0;  b_in[0*SIZE +: SIZE] = 8'h80;  // 0 * -128
    a_in[1*SIZE +: SIZE] = 8'd77; b_in[1*SIZE +: SIZE] = 8'hFD;  // 77 * -3
    a_in[2*SIZE +: SIZE] = 8'd5;  b_in[2*SIZE +: SIZE] = 8'd5;
    req = 4'b0111;
    collect(3, 500, 4'b0, 4'b0);
    checks++;
    if (ev_idx.size() !== 3 || st_cyc.size() !== 3) begin
      errors++; $display("FAIL edge_count: got %0d/%0d expected 3/3", ev_idx.size(), st_cyc.size());
    end else begin
      checks++;
      if (ev_done[0] !== 4'b0001 || ev_res[0] !== 16'd0) begin
        errors++; $display("FAIL zero_op: got done=%b res=%h expected 0001/0000", ev_done[0], ev_res[0]);
      end
      checks++;
      if (ev_done[1] !== 4'b0010 || ev_err[1] !== 4'b0 || ev_res[1] !== prodf(8'sd77, -8'sd3)) begin
        errors++; $display("FAIL edge_wins: got done=%b err=%b res=%h expected 0010/0000/%h",
                           ev_done[1], ev_err[1], ev_res[1], prodf(8'sd77, -8'sd3));
      end
      checks++;
      if (ev_cyc[1] - st_cyc[1] !== TMO + 1) begin
        errors++; $display("FAIL edge_timing: got %0d expected %0d", ev_cyc[1] - st_cyc[1], TMO + 1);
      end
      checks++;
      if (ev_err[2] !== 4'b0100 || ev_done[2] !== 4'b0 || ev_res[2] !== prodf(8'sd77, -8'sd3)) begin
        errors++; $display("FAIL late_edge_abort: got err=%b done=%b res=%h expected 0100/0000/%h",
                           ev_err[2], ev_done[2], ev_res[2], prodf(8'sd77, -8'sd3));
      end
    end
    exp_ptr = 3; last_exp_res = prodf(8'sd77, -8'sd3);
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_midop();
    int seen, stray;
    delay_q.delete(); delay_q.push_back(30);
    a_in[3*SIZE +: SIZE] = 8'd9; b_in[3*SIZE +: SIZE] = 8'd9;
    req = 4'b1000;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge CLK);
      if (start === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1) begin
      errors++; $display("FAIL rst_mid_start: got %0d expected 1", seen);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd3) begin
      errors++; $display("FAIL rst_mid_busy: got busy=%b owner=%0d expected 1/3", busy, owner);
    end
    #1 RESET_N = 1'b0;
    #1;
    checks++;
    if ({done, err, busy, start, owner} !== 11'b0 || {A, B, result} !== 32'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %0h/%0h expected 0/0",
                         {done, err, busy, start, owner}, {A, B, result});
    end
    req = '0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if ((done | err) !== 4'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL rst_mid_stray: got %0d expected 0", stray);
    end
    delay_q.delete();
    for (int i = 0; i < 4; i++) begin
      a_in[i*SIZE +: SIZE] = 8'(i + 2);
      b_in[i*SIZE +: SIZE] = 8'hFF;
      delay_q.push_back(1);
    end
    req = 4'b1111;
    collect(4, 200, 4'b0, 4'b0);
    checks++;
    if (ev_idx.size() !== 4) begin
      errors++; $display("FAIL rst_mid_after_count: got %0d expected 4", ev_idx.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ev_done[k] !== 4'(1 << k) || ev_res[k] !== 16'(-(k + 2))) begin
          errors++; $display("FAIL rst_mid_after_op%0d: got done=%b res=%h expected done=%b res=%h",
                             k, ev_done[k], ev_res[k], 4'(1 << k), 16'(-(k + 2)));
        end
      end
    end
    exp_ptr = 0; last_exp_res = 16'(-5);
  endtask

  task automatic test_random();
    logic [3:0] set;
    logic signed [7:0] sa[4], sb[4];
    int order[$];
    bit is_err[$];
    int d, ix, n;
    logic [15:0] er;
    for (int b = 0; b < 20; b++) begin
      set = 4'($urandom_range(1, 15));
      order.delete(); is_err.delete(); delay_q.delete();
      for (int i = 0; i < 4; i++) begin
        sa[i] = 8'($urandom); sb[i] = 8'($urandom);
        a_in[i*SIZE +: SIZE] = sa[i]; b_in[i*SIZE +: SIZE] = sb[i];
      end
      for (int off = 0; off < 4; off++) begin
        ix = (exp_ptr + off) % 4;
        if (set[ix]) order.push_back(ix);
      end
      foreach (order[k]) begin
        d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
        delay_q.push_back(d);
        is_err.push_back(d == 0);
      end
      scr_q = order;
      n = order.size();
      req = set;
      collect(n, 600, 4'b0, 4'b0);
      checks++;
      if (ev_idx.size() !== n || st_cyc.size() !== n) begin
        errors++; $display("FAIL rand%0d_count: got %0d/%0d expected %0d", b, ev_idx.size(), st_cyc.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          ix = order[k];
          er = is_err[k] ? last_exp_res : prodf(sa[ix], sb[ix]);
          checks++;
          if ((is_err[k] ? ev_err[k] : ev_done[k]) !== 4'(1 << ix) ||
              (is_err[k] ? ev_done[k] : ev_err[k]) !== 4'b0 || ev_res[k] !== er) begin
            errors++; $display("FAIL rand%0d_op%0d: got done=%b err=%b res=%h expected idx=%0d err=%0d res=%h",
                               b, k, ev_done[k], ev_err[k], ev_res[k], ix, is_err[k], er);
          end
          last_exp_res = er;
        end
      end
      exp_ptr = (order[n-1] + 1) % 4;
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_mask();
    test_timeout();
    test_zero_coincide();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
